// File: rtl/addsub_seq.sv
// addsub_seq: WIDTH-bit add/sub done one nibble per clock on a shared 4-bit slice.
// Optional `ADDSUB_SEQ_ZERO_EN adds a registered all-zero result flag (zero).
module full_add (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module addsub_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
`ifdef ADDSUB_SEQ_ZERO_EN
  ,
  output logic             zero
`endif
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic c_q, c_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic m_q, m_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic co_q, co_d;
  logic ov_q, ov_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
`ifdef ADDSUB_SEQ_ZERO_EN
  logic zacc_q, zacc_d;
  logic zero_q, zero_d;
`endif

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] sum;
  logic [4:0] c;
  logic last;

  assign a_nib = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib = b_q[{idx_q, 2'b00} +: 4] ^ {4{m_q}};
  assign c[0] = c_q;
  assign last = (idx_q == IW'(NIBBLES - 1));

  for (genvar i = 0; i < 4; i++) begin : g_slice
    full_add u_fa (
      .a_i(a_nib[i]),
      .b_i(b_nib[i]),
      .c_i(c[i]),
      .s_o(sum[i]),
      .c_o(c[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    res_d   = res_q;
    co_d    = co_q;
    ov_d    = ov_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef ADDSUB_SEQ_ZERO_EN
    zacc_d  = zacc_q;
    zero_d  = zero_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          m_d     = mode;
          c_d     = mode;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef ADDSUB_SEQ_ZERO_EN
          zacc_d  = 1'b1;
`endif
        end
      end
      RUN: begin
        res_d[{idx_q, 2'b00} +: 4] = sum;
        c_d   = c[4];
        idx_d = idx_q + IW'(1);
`ifdef ADDSUB_SEQ_ZERO_EN
        zacc_d = zacc_q & ~(|sum);
`endif
        if (last) begin
          co_d    = c[4];
          ov_d    = c[3] ^ c[4];
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = DONE;
`ifdef ADDSUB_SEQ_ZERO_EN
          zero_d  = zacc_q & ~(|sum);
`endif
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      res_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADDSUB_SEQ_ZERO_EN
      zacc_q  <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      res_q   <= res_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ADDSUB_SEQ_ZERO_EN
      zacc_q  <= zacc_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign result    = res_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef ADDSUB_SEQ_ZERO_EN
  assign zero      = zero_q;
`endif
endmodule
